// File: rtl/reg_file_param.sv
// ---------------------------------------------------------------------------
// reg_file_param
//   Parameterised register file: two combinational read ports, one
//   synchronous write port. After reset is released, a CLEAR sequence walks
//   every register and writes zero, one register per clock. While it runs,
//   busy is high, writes are dropped and both read ports return zero.
//
// Parameters
//   DATA_W   register width in bits
//   ADDR_W   address width, DEPTH = 2**ADDR_W registers
//   ZERO_REG 1: register 0 reads as zero and ignores writes
//            0: register 0 is ordinary storage
//
// Ports
//   clk       single clock, rising edge
//   reset     asynchronous, active-high; restarts the CLEAR sequence
//   A1, A2    read addresses for RD1, RD2
//   A3        write address
//   WD3       write data
//   WE3       write enable, sampled on rising clk
//   RD1, RD2  combinational read data
//   busy      high while the CLEAR sequence runs
//
// Optional feature
//   REGFILE_BYPASS_EN  when defined, a write in progress is forwarded
//                      combinationally to a read port whose address matches
//                      A3 (never while busy, never to register 0 when
//                      ZERO_REG=1). When undefined, a read of A3 in the write
//                      cycle returns the pre-write value.
//
// Handshake: none. WE3 is a plain strobe, honoured only when busy is low.
// ---------------------------------------------------------------------------
module reg_file_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    input  logic [ADDR_W-1:0] A3,
    input  logic [DATA_W-1:0] WD3,
    input  logic              WE3,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_next;
    logic              wr_en;

    // Storage has no reset: zeroing is the job of the CLEAR sequence.
    logic [DATA_W-1:0] regs [DEPTH];

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

    // Next state and busy
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        busy       = 1'b0;
        case (state)
            CLEAR: begin
                busy     = 1'b1;
                ptr_next = ptr + ADDR_W'(1);   // wraps to 0 after DEPTH-1
                if (&ptr) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                // Only reset leaves RUN.
            end
            default: begin
                state_next = CLEAR;
            end
        endcase
    end

    // A user write lands only in RUN and never on a hardwired register 0.
    always_comb begin
        wr_en = (state == RUN) && WE3;
        if ((ZERO_REG != 0) && (A3 == '0)) begin
            wr_en = 1'b0;
        end
    end

    // Storage update: clear walk in CLEAR, user write in RUN.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            regs[ptr] <= '0;
        end else if (wr_en) begin
            regs[A3] <= WD3;
        end
    end

    // Read port 1; later assignments take priority.
    always_comb begin
        RD1 = regs[A1];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (A3 == A1)) begin
            RD1 = WD3;
        end
`endif
        if ((ZERO_REG != 0) && (A1 == '0)) begin
            RD1 = '0;
        end
        if (busy) begin
            RD1 = '0;
        end
    end

    // Read port 2; same priority as port 1.
    always_comb begin
        RD2 = regs[A2];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (A3 == A2)) begin
            RD2 = WD3;
        end
`endif
        if ((ZERO_REG != 0) && (A2 == '0)) begin
            RD2 = '0;
        end
        if (busy) begin
            RD2 = '0;
        end
    end

endmodule

// File: doc/reg_file_param.md
REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 Parameter DATA_W, default 32, register width in bits.
REQ-002 Parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W registers.
REQ-003 Parameter ZERO_REG, default 1; 1 = register 0 hardwired to zero, 0 = register 0 is ordinary storage.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 A1  input  ADDR_W  read port 1 address.
REQ-007 A2  input  ADDR_W  read port 2 address.
REQ-008 A3  input  ADDR_W  write port address.
REQ-009 WD3  input  DATA_W  write data.
REQ-010 WE3  input  1  write enable, sampled on rising clk.
REQ-011 RD1  output  DATA_W  read data, port 1, combinational from A1.
REQ-012 RD2  output  DATA_W  read data, port 2, combinational from A2.
REQ-013 busy  output  1  high while the clear sequence runs; writes ignored, reads forced to zero.

Function
REQ-014 FSM states: CLEAR, RUN; clear pointer ptr is ADDR_W bits.
REQ-015 In CLEAR, each rising clk writes 0 to registers[ptr] and increments ptr.
REQ-016 CLEAR -> RUN on the edge that clears ptr = DEPTH-1; ptr wraps to 0; busy deasserts after that edge.
REQ-017 busy = 1 exactly for DEPTH rising edges after reset deassertion, 0 thereafter.
REQ-018 RUN -> CLEAR only via reset; no other transition.
REQ-019 In RUN, WE3=1 at rising clk writes WD3 to registers[A3]; visible on RD1/RD2 in the same cycle after the edge.
REQ-020 WE3 while busy=1 is discarded; no register changes other than the clear write.
REQ-021 RD1/RD2 = 0 while busy=1, regardless of address.
REQ-022 ZERO_REG=1: writes to address 0 discarded; RD1/RD2 = 0 whenever the respective address is 0.
REQ-023 A1 = A2 legal; both ports return identical data.
REQ-024 No read-during-write forwarding unless REQ-029 applies; read of A3 in the write cycle returns the pre-write value.
REQ-025 No X propagation: every register holds a defined value once busy falls.

Reset
REQ-026 reset=1 asynchronously forces state=CLEAR, ptr=0, busy=1, RD1=RD2=0, independent of clk.
REQ-027 Register array not cleared by reset itself; clearing is done by the CLEAR sequence after release.
REQ-028 reset asserted mid-CLEAR or mid-RUN restarts the sequence from ptr=0; a write coincident with the reset edge is lost.

Configuration
REQ-029 Macro REGFILE_BYPASS_EN defined: in RUN, if WE3=1 and A3 = A1 (A2), RD1 (RD2) = WD3 combinationally in the same cycle, except A3=0 when ZERO_REG=1 (reads stay 0).
REQ-030 Macro REGFILE_BYPASS_EN undefined: no forwarding; REQ-024 governs.
REQ-031 The bypass never applies while busy=1.

Verification
REQ-032 Default params, release reset -> busy=1 for exactly 32 edges, then 0; all 32 registers read 0.
REQ-033 RUN, A3=5, WD3=0xDEADBEEF, WE3=1 one edge; A1=5, A2=5 -> RD1=RD2=0xDEADBEEF.
REQ-034 ZERO_REG=1, write 0x12345678 to A3=0 -> RD1 at A1=0 reads 0; ZERO_REG=0 -> reads 0x12345678.
REQ-035 busy=1, WE3=1, A3=7, WD3=0xFFFFFFFF -> after busy falls, register 7 reads 0.
REQ-036 Register 9 holds 0xA5A5A5A5; assert reset mid-cycle -> busy=1 and RD1=0 immediately; after 32 edges register 9 reads 0.
REQ-037 REGFILE_BYPASS_EN defined, WE3=1, A3=A1=3, WD3=0x0000CAFE -> RD1=0x0000CAFE before the edge; undefined -> old value until the edge.
